sensor_adc_axil_slave: RTL and testbench
========================================

Name: sensor_adc_axil_slave

Overview:
AXI4-Lite responder (slave) for the sensor ADC IP, i.e. the register-file end of the bus that the master VIP drives. It provides four read/write configuration registers, a read-only latest-sample register and a status register with sticky, write-1-to-clear flags. It captures samples from the ADC front end, compares each against a programmable threshold and raises an interrupt.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.
ADC_W, 12, ADC sample width; must be ≤ 16.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
adc_valid  in  1  one-cycle sample strobe
adc_data  in  ADC_W  sample value
ctrl_out  out  32  mirror of REG0
irq  out  1  interrupt, level

Behaviour:
- Reset: all READY/VALID outputs, BRESP/RRESP/RDATA, REG0-REG5, holding registers and irq are 0. READYs rise in the first cycle after ARESET deasserts. Reset in mid-transaction drops any pending AW/W/B/AR/R state; no response is issued.
- Word index is ADDR[4:2]. ADDR[1:0] is ignored.
- Register map:
  - 0-3: REG0-REG3, RW. REG0 bit0 is sample enable, bit1 is irq enable. REG1[ADC_W-1:0] is the threshold.
  - 4: ADC_DATA, RO. Holds the latest sample, zero-extended.
  - 5: STATUS. bit0 = sample_seen (sticky). bit1 = over_thresh (sticky). [31:16] = sample count. Writing 1 to bit0 or bit1 clears that bit; the count is read-only.
  - 6-7: unmapped.
- Write path:
  - AW and W are accepted independently into one-deep holding registers.
  - AWREADY=1 while no AW is held and BVALID=0. WREADY=1 while no W is held and BVALID=0.
  - Commit happens at the first edge where both AW and W are held and BVALID=0. The registers update with byte lanes gated by WSTRB, BVALID rises at that same edge and the holding registers clear.
  - AW and W handshaking on the same edge E: commit and BVALID at E+1.
  - BVALID holds until BREADY. No new AW/W is accepted while BVALID=1.
  - BRESP=OKAY for index 0-5. A write to index 4 is silently ignored with OKAY. Index 6-7 returns SLVERR with no state change.
- Read path:
  - ARREADY=1 while RVALID=0.
  - At the AR handshake edge, RDATA is sampled from current register values and RVALID rises: latency 1.
  - RDATA/RRESP hold until RREADY.
  - Index 6-7 returns RDATA=0 with RRESP=SLVERR.
  - A read on the same edge as a write commit to the same register returns the old value.
  - Reads have no side effects.
- ADC capture (only when REG0[0]=1; otherwise adc_valid is ignored entirely). On an adc_valid edge:
  - ADC_DATA ← adc_data.
  - The count increments modulo 2^16 (0xFFFF→0x0000).
  - sample_seen ← 1.
  - If adc_data > REG1[ADC_W-1:0] (unsigned, strictly greater), over_thresh ← 1. Equal to the threshold does not set it.
- Set/clear collision: a W1C commit and a set event on the same edge leave the bit at 1 (set wins). The count still increments.
- irq = over_thresh & REG0[1], registered (valid one cycle after the status update).
- ctrl_out is combinational from REG0.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read back → each read returns the same value, all BRESP/RRESP=OKAY.
- Write 0xAABBCCDD to 0x04, then 0x11223344 with WSTRB=0b0101 → read 0x04 gives 0xAA22CC44.
- Write to 0x18 → BRESP=SLVERR with no register change. Read 0x1C → RDATA=0, RRESP=SLVERR.
- REG0=0x3, REG1=0x800, adc_valid with 0x800 then 0x801 → ADC_DATA=0x801, STATUS=0x00020003, irq=1. Write 0x2 to 0x14 → over_thresh clears, irq=0, STATUS=0x00020001.
- Issue AW with W delayed 5 cycles and BREADY held low 4 cycles → AWREADY=0 until B completes. The B response and commit occur exactly once; a second AW waits.
- W1C of bit1 on the same edge as an over-threshold sample → bit1 stays 1. With REG0[0]=0, samples do not change STATUS. Assert ARESET mid-write → all outputs return to 0 and no BVALID appears.

Source files
------------

// File: rtl/sensor_adc_axil_slave.sv
// Sensor ADC AXI4-Lite register slave: four RW config registers, latest-sample
// capture, sticky W1C status with sample count, and a level threshold interrupt.
module sensor_adc_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int ADC_W              = 12
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            adc_valid,
  input  logic [ADC_W-1:0]                adc_data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_out,
  output logic                            irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge new write data into an existing word, one byte lane per strobe bit.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic              awready_r;
  logic              wready_r;
  logic              bvalid_r;
  logic [1:0]        bresp_r;
  logic              arready_r;
  logic              rvalid_r;
  logic [1:0]        rresp_r;
  logic [DW-1:0]     rdata_r;
  logic              irq_r;

  logic              aw_held_r;
  logic [2:0]        aw_idx_r;
  logic              w_held_r;
  logic [DW-1:0]     wdata_r;
  logic [SW-1:0]     wstrb_r;

  logic [DW-1:0]     reg0_r;
  logic [DW-1:0]     reg1_r;
  logic [DW-1:0]     reg2_r;
  logic [DW-1:0]     reg3_r;
  logic [ADC_W-1:0]  adc_data_r;
  logic              sample_seen_r;
  logic              over_thresh_r;
  logic [15:0]       count_r;

  logic              aw_hs_s;
  logic              w_hs_s;
  logic              ar_hs_s;
  logic              commit_s;
  logic              sample_ev_s;
  logic              over_s;
  logic              aw_held_nxt_s;
  logic              w_held_nxt_s;
  logic              bvalid_nxt_s;
  logic              rvalid_nxt_s;
  logic [1:0]        w1c_s;
  logic [2:0]        ar_idx_s;
  logic [DW-1:0]     status_s;
  logic [DW-1:0]     adc_word_s;
  logic [DW-1:0]     rd_data_s;
  logic [1:0]        rd_resp_s;
  logic              unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Handshake, commit and sample-event qualification.
  always_comb begin
    aw_hs_s     = S_AXI_AWVALID & awready_r;
    w_hs_s      = S_AXI_WVALID & wready_r;
    ar_hs_s     = S_AXI_ARVALID & arready_r;
    commit_s    = aw_held_r & w_held_r & ~bvalid_r;
    sample_ev_s = reg0_r[0] & adc_valid;
    over_s      = sample_ev_s & (adc_data > reg1_r[ADC_W-1:0]);
    ar_idx_s    = S_AXI_ARADDR[4:2];
  end

  // Next-state of the channel occupancy flags; the READYs are registered from these.
  always_comb begin
    if (commit_s) begin
      aw_held_nxt_s = 1'b0;
    end else if (aw_hs_s) begin
      aw_held_nxt_s = 1'b1;
    end else begin
      aw_held_nxt_s = aw_held_r;
    end

    if (commit_s) begin
      w_held_nxt_s = 1'b0;
    end else if (w_hs_s) begin
      w_held_nxt_s = 1'b1;
    end else begin
      w_held_nxt_s = w_held_r;
    end

    if (commit_s) begin
      bvalid_nxt_s = 1'b1;
    end else if (bvalid_r & S_AXI_BREADY) begin
      bvalid_nxt_s = 1'b0;
    end else begin
      bvalid_nxt_s = bvalid_r;
    end

    if (ar_hs_s) begin
      rvalid_nxt_s = 1'b1;
    end else if (rvalid_r & S_AXI_RREADY) begin
      rvalid_nxt_s = 1'b0;
    end else begin
      rvalid_nxt_s = rvalid_r;
    end
  end

  // Status clear mask from a committed write to STATUS (bits live in byte lane 0).
  always_comb begin
    if (commit_s && (aw_idx_r == 3'd5)) begin
      w1c_s = wdata_r[1:0] & {2{wstrb_r[0]}};
    end else begin
      w1c_s = 2'b00;
    end
  end

  // Read data mux over the current register values.
  always_comb begin
    status_s   = {count_r, 14'd0, over_thresh_r, sample_seen_r};
    adc_word_s = {{(DW-ADC_W){1'b0}}, adc_data_r};
    rd_resp_s  = RESP_OKAY;
    case (ar_idx_s)
      3'd0:    rd_data_s = reg0_r;
      3'd1:    rd_data_s = reg1_r;
      3'd2:    rd_data_s = reg2_r;
      3'd3:    rd_data_s = reg3_r;
      3'd4:    rd_data_s = adc_word_s;
      3'd5:    rd_data_s = status_s;
      default: begin
        rd_data_s = {DW{1'b0}};
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Write channel holding registers, B response and channel readiness.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_r <= 1'b0;
      aw_idx_r  <= 3'd0;
      w_held_r  <= 1'b0;
      wdata_r   <= {DW{1'b0}};
      wstrb_r   <= {SW{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
    end else begin
      aw_held_r <= aw_held_nxt_s;
      w_held_r  <= w_held_nxt_s;
      bvalid_r  <= bvalid_nxt_s;
      awready_r <= ~aw_held_nxt_s & ~bvalid_nxt_s;
      wready_r  <= ~w_held_nxt_s & ~bvalid_nxt_s;
      if (aw_hs_s) begin
        aw_idx_r <= S_AXI_AWADDR[4:2];
      end
      if (w_hs_s) begin
        wdata_r <= S_AXI_WDATA;
        wstrb_r <= S_AXI_WSTRB;
      end
      if (commit_s) begin
        bresp_r <= (aw_idx_r <= 3'd5) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Configuration registers; ADC_DATA, STATUS and unmapped slots are not written here.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      reg0_r <= {DW{1'b0}};
      reg1_r <= {DW{1'b0}};
      reg2_r <= {DW{1'b0}};
      reg3_r <= {DW{1'b0}};
    end else if (commit_s) begin
      case (aw_idx_r)
        3'd0:    reg0_r <= apply_strb(reg0_r, wdata_r, wstrb_r);
        3'd1:    reg1_r <= apply_strb(reg1_r, wdata_r, wstrb_r);
        3'd2:    reg2_r <= apply_strb(reg2_r, wdata_r, wstrb_r);
        3'd3:    reg3_r <= apply_strb(reg3_r, wdata_r, wstrb_r);
        default: begin
        end
      endcase
    end
  end

  // Sample capture and sticky flags; a set event beats a same-cycle clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      adc_data_r    <= {ADC_W{1'b0}};
      count_r       <= 16'd0;
      sample_seen_r <= 1'b0;
      over_thresh_r <= 1'b0;
      irq_r         <= 1'b0;
    end else begin
      if (sample_ev_s) begin
        adc_data_r <= adc_data;
        count_r    <= count_r + 16'd1;
      end
      sample_seen_r <= sample_ev_s | (sample_seen_r & ~w1c_s[0]);
      over_thresh_r <= over_s | (over_thresh_r & ~w1c_s[1]);
      irq_r         <= over_thresh_r & reg0_r[1];
    end
  end

  // Read channel: data captured at the AR handshake and held until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      rresp_r   <= RESP_OKAY;
      arready_r <= 1'b0;
    end else begin
      rvalid_r  <= rvalid_nxt_s;
      arready_r <= ~rvalid_nxt_s;
      if (ar_hs_s) begin
        rdata_r <= rd_data_s;
        rresp_r <= rd_resp_s;
      end
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RDATA   = rdata_r;
  assign S_AXI_RRESP   = rresp_r;
  assign ctrl_out      = reg0_r;
  assign irq           = irq_r;

endmodule

// File: tb/tb_sensor_adc_axil_slave.sv
// Directed bench for sensor_adc_axil_slave: expected B/R responses are queued
// when a transaction is issued and compared when the DUT answers.
module tb_sensor_adc_axil_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int LIMIT = 50;

  logic        aclk_s    = 1'b0;
  logic        areset_s  = 1'b1;
  logic [4:0]  awaddr_s  = 5'd0;
  logic        awvalid_s = 1'b0;
  logic [31:0] wdata_s   = 32'd0;
  logic [3:0]  wstrb_s   = 4'd0;
  logic        wvalid_s  = 1'b0;
  logic        bready_s  = 1'b0;
  logic [4:0]  araddr_s  = 5'd0;
  logic        arvalid_s = 1'b0;
  logic        rready_s  = 1'b0;
  logic        adc_valid_s = 1'b0;
  logic [11:0] adc_data_s  = 12'd0;

  logic        awready_s;
  logic        wready_s;
  logic [1:0]  bresp_s;
  logic        bvalid_s;
  logic        arready_s;
  logic [31:0] rdata_s;
  logic [1:0]  rresp_s;
  logic        rvalid_s;
  logic [31:0] ctrl_out_s;
  logic        irq_s;

  int tests_run_s    = 0;
  int tests_failed_s = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [1:0] b_q[$];

  sensor_adc_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .ADC_W(12)
  ) dut (
    .ACLK(aclk_s),
    .ARESET(areset_s),
    .S_AXI_AWADDR(awaddr_s),
    .S_AXI_AWPROT(3'd0),
    .S_AXI_AWVALID(awvalid_s),
    .S_AXI_AWREADY(awready_s),
    .S_AXI_WDATA(wdata_s),
    .S_AXI_WSTRB(wstrb_s),
    .S_AXI_WVALID(wvalid_s),
    .S_AXI_WREADY(wready_s),
    .S_AXI_BRESP(bresp_s),
    .S_AXI_BVALID(bvalid_s),
    .S_AXI_BREADY(bready_s),
    .S_AXI_ARADDR(araddr_s),
    .S_AXI_ARPROT(3'd0),
    .S_AXI_ARVALID(arvalid_s),
    .S_AXI_ARREADY(arready_s),
    .S_AXI_RDATA(rdata_s),
    .S_AXI_RRESP(rresp_s),
    .S_AXI_RVALID(rvalid_s),
    .S_AXI_RREADY(rready_s),
    .adc_valid(adc_valid_s),
    .adc_data(adc_data_s),
    .ctrl_out(ctrl_out_s),
    .irq(irq_s)
  );

  // Free-running 100 MHz clock.
  always #5 aclk_s = ~aclk_s;

  // Hard stop in case a handshake never completes.
  initial begin
    #2000000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run_s++;
    assert (obs === exp) else begin
      tests_failed_s++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk_s);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    logic aw_done, w_done, aw_take, w_take;
    int n;
    b_q.push_back(er);
    awaddr_s = a; wdata_s = d; wstrb_s = s;
    awvalid_s = 1'b1; wvalid_s = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < LIMIT) begin
      aw_take = awvalid_s & awready_s;
      w_take  = wvalid_s & wready_s;
      tick(); n++;
      if (aw_take) begin aw_done = 1'b1; awvalid_s = 1'b0; end
      if (w_take)  begin w_done  = 1'b1; wvalid_s  = 1'b0; end
    end
    awvalid_s = 1'b0; wvalid_s = 1'b0;
    chk("wr_addr_data_timeout", {31'd0, aw_done & w_done}, 32'd1);
    bready_s = 1'b1;
    n = 0;
    while (!bvalid_s && n < LIMIT) begin tick(); n++; end
    chk("wr_bvalid_timeout", {31'd0, bvalid_s}, 32'd1);
    chk("wr_bresp", {30'd0, bresp_s}, {30'd0, b_q.pop_front()});
    tick();
    bready_s = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] ed,
                          input logic [1:0] er, input int rdly);
    rd_exp_t e;
    int n;
    rd_q.push_back('{data: ed, resp: er});
    araddr_s = a; arvalid_s = 1'b1;
    n = 0;
    while (!arready_s && n < LIMIT) begin tick(); n++; end
    chk("rd_arready_timeout", {31'd0, arready_s}, 32'd1);
    tick();
    arvalid_s = 1'b0;
    chk("rd_latency", {31'd0, rvalid_s}, 32'd1);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("rd_rvalid_hold", {31'd0, rvalid_s}, 32'd1);
    end
    e = rd_q.pop_front();
    chk("rd_data", rdata_s, e.data);
    chk("rd_resp", {30'd0, rresp_s}, {30'd0, e.resp});
    rready_s = 1'b1;
    tick();
    rready_s = 1'b0;
  endtask

  task automatic adc_pulse(input logic [11:0] d);
    adc_data_s = d; adc_valid_s = 1'b1;
    tick();
    adc_valid_s = 1'b0;
    tick();
  endtask

  task automatic chk_idle_zero(input string tag);
    chk(tag, {22'd0, awready_s, wready_s, arready_s, bvalid_s, rvalid_s,
              bresp_s, rresp_s, irq_s}, 32'd0);
    chk({tag, "_rdata"}, rdata_s, 32'd0);
    chk({tag, "_ctrl"}, ctrl_out_s, 32'd0);
  endtask

  initial begin
    // Reset state, then READYs one cycle after release.
    repeat (3) tick();
    chk_idle_zero("reset_outputs");
    areset_s = 1'b0;
    tick();
    chk("ready_after_reset", {29'd0, awready_s, wready_s, arready_s}, 32'd7);

    // RW registers write/readback.
    for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, OKAY);
    for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 32'(i + 1), OKAY, 0);
    chk("ctrl_out_mirror", ctrl_out_s, 32'h1);

    // Byte-lane strobes, with RREADY held off for a few cycles.
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, OKAY);
    axi_write(5'h04, 32'h11223344, 4'b0101, OKAY);
    axi_read(5'h04, 32'hAA22CC44, OKAY, 3);

    // Unmapped slots and the read-only sample register.
    axi_write(5'h18, 32'hDEADBEEF, 4'hF, SLVERR);
    axi_write(5'h10, 32'h00000ABC, 4'hF, OKAY);
    axi_read(5'h00, 32'h1, OKAY, 0);
    axi_read(5'h04, 32'hAA22CC44, OKAY, 0);
    axi_read(5'h08, 32'h3, OKAY, 0);
    axi_read(5'h0C, 32'h4, OKAY, 0);
    axi_read(5'h10, 32'h0, OKAY, 0);
    axi_read(5'h14, 32'h0, OKAY, 0);
    axi_read(5'h1C, 32'h0, SLVERR, 0);
    axi_read(5'h1A, 32'h0, SLVERR, 0);

    // Threshold: equal does not set over_thresh, greater does.
    axi_write(5'h00, 32'h3, 4'hF, OKAY);
    axi_write(5'h04, 32'h800, 4'hF, OKAY);
    chk("ctrl_out_en", ctrl_out_s, 32'h3);
    adc_pulse(12'h800);
    axi_read(5'h14, 32'h00010001, OKAY, 0);
    chk("irq_equal_thresh", {31'd0, irq_s}, 32'd0);
    adc_pulse(12'h801);
    axi_read(5'h10, 32'h801, OKAY, 0);
    axi_read(5'h14, 32'h00020003, OKAY, 0);
    chk("irq_over_thresh", {31'd0, irq_s}, 32'd1);
    axi_write(5'h14, 32'h2, 4'hF, OKAY);
    axi_read(5'h14, 32'h00020001, OKAY, 0);
    chk("irq_cleared", {31'd0, irq_s}, 32'd0);

    // AW first, W five cycles later, BREADY low four cycles; a second AW waits.
    b_q.push_back(OKAY);
    chk("dly_awready_pre", {31'd0, awready_s}, 32'd1);
    awaddr_s = 5'h08; awvalid_s = 1'b1;
    tick();
    awvalid_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("dly_awready_held", {31'd0, awready_s}, 32'd0);
      chk("dly_no_early_b", {31'd0, bvalid_s}, 32'd0);
      tick();
    end
    awaddr_s = 5'h0C; awvalid_s = 1'b1;
    chk("dly_wready", {31'd0, wready_s}, 32'd1);
    wdata_s = 32'h55; wstrb_s = 4'hF; wvalid_s = 1'b1;
    tick();
    wvalid_s = 1'b0;
    tick();
    chk("dly_bvalid", {31'd0, bvalid_s}, 32'd1);
    chk("dly_bresp", {30'd0, bresp_s}, {30'd0, b_q.pop_front()});
    for (int i = 0; i < 4; i++) begin
      chk("dly_bvalid_hold", {31'd0, bvalid_s}, 32'd1);
      chk("dly_awready_during_b", {31'd0, awready_s}, 32'd0);
      tick();
    end
    bready_s = 1'b1;
    tick();
    bready_s = 1'b0;
    chk("dly_single_b", {31'd0, bvalid_s}, 32'd0);
    chk("dly_awready_after_b", {31'd0, awready_s}, 32'd1);
    tick();
    awvalid_s = 1'b0;
    chk("dly_second_aw_taken", {31'd0, awready_s}, 32'd0);
    chk("dly_no_extra_b", {31'd0, bvalid_s}, 32'd0);
    b_q.push_back(OKAY);
    wdata_s = 32'h66; wvalid_s = 1'b1;
    tick();
    wvalid_s = 1'b0;
    tick();
    chk("dly2_bvalid", {31'd0, bvalid_s}, 32'd1);
    chk("dly2_bresp", {30'd0, bresp_s}, {30'd0, b_q.pop_front()});
    bready_s = 1'b1;
    tick();
    bready_s = 1'b0;
    axi_read(5'h08, 32'h55, OKAY, 0);
    axi_read(5'h0C, 32'h66, OKAY, 0);

    // Read on the commit edge of a write to the same register sees the old value.
    rd_q.push_back('{data: 32'h66, resp: OKAY});
    b_q.push_back(OKAY);
    awaddr_s = 5'h0C; wdata_s = 32'h77; wstrb_s = 4'hF;
    awvalid_s = 1'b1; wvalid_s = 1'b1;
    tick();
    awvalid_s = 1'b0; wvalid_s = 1'b0;
    araddr_s = 5'h0C; arvalid_s = 1'b1;
    tick();
    arvalid_s = 1'b0;
    begin
      rd_exp_t e;
      e = rd_q.pop_front();
      chk("coll_rvalid", {31'd0, rvalid_s}, 32'd1);
      chk("coll_rdata_old", rdata_s, e.data);
      chk("coll_rresp", {30'd0, rresp_s}, {30'd0, e.resp});
    end
    chk("coll_bvalid", {31'd0, bvalid_s}, 32'd1);
    chk("coll_bresp", {30'd0, bresp_s}, {30'd0, b_q.pop_front()});
    rready_s = 1'b1; bready_s = 1'b1;
    tick();
    rready_s = 1'b0; bready_s = 1'b0;
    axi_read(5'h0C, 32'h77, OKAY, 0);

    // W1C of over_thresh on the same edge as an over-threshold sample: set wins.
    b_q.push_back(OKAY);
    awaddr_s = 5'h14; wdata_s = 32'h2; wstrb_s = 4'hF;
    awvalid_s = 1'b1; wvalid_s = 1'b1;
    tick();
    awvalid_s = 1'b0; wvalid_s = 1'b0;
    adc_data_s = 12'h900; adc_valid_s = 1'b1;
    tick();
    adc_valid_s = 1'b0;
    chk("w1c_coll_bvalid", {31'd0, bvalid_s}, 32'd1);
    chk("w1c_coll_bresp", {30'd0, bresp_s}, {30'd0, b_q.pop_front()});
    bready_s = 1'b1;
    tick();
    bready_s = 1'b0;
    axi_read(5'h14, 32'h00030003, OKAY, 0);
    chk("w1c_coll_irq", {31'd0, irq_s}, 32'd1);

    // Clear both flags, disable sampling: samples are then ignored.
    axi_write(5'h14, 32'h3, 4'hF, OKAY);
    axi_read(5'h14, 32'h00030000, OKAY, 0);
    axi_write(5'h00, 32'h2, 4'hF, OKAY);
    adc_pulse(12'hFFF);
    adc_pulse(12'hFFF);
    axi_read(5'h14, 32'h00030000, OKAY, 0);
    axi_read(5'h10, 32'h900, OKAY, 0);
    chk("disabled_irq", {31'd0, irq_s}, 32'd0);

    // Reset with an AW held and W outstanding: nothing survives.
    awaddr_s = 5'h08; awvalid_s = 1'b1;
    tick();
    awvalid_s = 1'b0;
    areset_s = 1'b1;
    tick();
    tick();
    chk_idle_zero("midreset_outputs");
    areset_s = 1'b0;
    tick();
    wdata_s = 32'h99; wstrb_s = 4'hF; wvalid_s = 1'b1;
    tick();
    wvalid_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midreset_no_b", {31'd0, bvalid_s}, 32'd0);
      tick();
    end
    axi_read(5'h08, 32'h0, OKAY, 0);
    axi_read(5'h00, 32'h0, OKAY, 0);
    axi_read(5'h14, 32'h0, OKAY, 0);
    chk("midreset_ctrl", ctrl_out_s, 32'h0);
    chk("midreset_irq", {31'd0, irq_s}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run_s, tests_failed_s);
    $finish;
  end

endmodule
